// File: rtl/bus_pkg.sv
// Shared types and default widths for the burst bus master.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_CMD,
    RD_DATA
  } state_e;

  localparam int unsigned DEF_ADDR_W  = 4;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_LEN_W   = 4;
  localparam int unsigned DEF_TIMEOUT = 64;

endpackage

// File: rtl/burst_bus_master_if.sv
// Client command/data stream plus interconnect signals of the burst bus master.
interface burst_bus_master_if
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;
  logic              err;
  logic              busy;
  logic              bus_wr;
  logic              bus_rd;
  logic [ADDR_W-1:0] bus_address;
  logic [LEN_W-1:0]  bus_length;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ready;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rddatavalid;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata_valid, wdata,
           bus_ready, bus_rdata, bus_rddatavalid,
    output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, err, busy,
           bus_wr, bus_rd, bus_address, bus_length, bus_wdata
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata_valid, wdata,
           bus_ready, bus_rdata, bus_rddatavalid,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, err, busy,
           bus_wr, bus_rd, bus_address, bus_length, bus_wdata
  );

endinterface

// File: rtl/burst_beat_counter.sv
// Remaining-beat counter: loads the burst length, decrements per beat, saturates at 0.
module burst_beat_counter #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             dec_i,
  output logic [LEN_W-1:0] cnt_o,
  output logic             last_o
);

  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = len_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/burst_bus_master.sv
// Converts client commands into write/read bursts on the interconnect, with
// read beat counting, last-beat flag and an inter-beat read timeout.
module burst_bus_master
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  burst_bus_master_if.master bus
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [TMR_W-1:0]  timer_q, timer_d, timer_inc;

  logic              cnt_load, cnt_dec, cnt_last;
  logic [LEN_W-1:0]  cnt_val;
  logic              rd_beat;

  logic              cmd_ready_c, wdata_ready_c, bus_wr_c, bus_rd_c;
  logic [DATA_W-1:0] bus_wdata_c;

  burst_beat_counter #(.LEN_W(LEN_W)) u_beat_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (cnt_load),
    .len_i  (bus.cmd_len),
    .dec_i  (cnt_dec),
    .cnt_o  (cnt_val),
    .last_o (cnt_last)
  );

  assign timer_inc = timer_q + TMR_W'(1);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    err_d         = 1'b0;
    rvalid_d      = 1'b0;
    rlast_d       = 1'b0;
    rdata_d       = rdata_q;
    timer_d       = timer_q;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    rd_beat       = 1'b0;
    cmd_ready_c   = 1'b0;
    wdata_ready_c = 1'b0;
    bus_wr_c      = 1'b0;
    bus_rd_c      = 1'b0;
    bus_wdata_c   = '0;

    unique case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_addr;
          len_d  = bus.cmd_len;
          if (bus.cmd_len == '0) begin
            err_d = 1'b1;
          end else begin
            cnt_load = 1'b1;
            state_d  = bus.cmd_wr ? WR_BURST : RD_CMD;
          end
        end
      end
      WR_BURST: begin
        bus_wr_c      = bus.wdata_valid;
        bus_wdata_c   = bus.wdata;
        wdata_ready_c = bus.bus_ready;
        if (bus.wdata_valid && bus.bus_ready) begin
          cnt_dec = 1'b1;
          if (cnt_last) state_d = IDLE;
        end
      end
      RD_CMD: begin
        bus_rd_c = 1'b1;
        timer_d  = '0;
        rd_beat  = bus.bus_rddatavalid;
        if (bus.bus_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rd_beat = bus.bus_rddatavalid;
        if (bus.bus_rddatavalid) begin
          timer_d = '0;
        end else if (timer_q != TMR_W'(TIMEOUT)) begin
          timer_d = timer_inc;
          if (timer_inc == TMR_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase

    // Beats arriving while the request is still in RD_CMD count too, so a
    // single-beat read can finish without ever entering RD_DATA.
    if (rd_beat) begin
      cnt_dec  = 1'b1;
      rvalid_d = 1'b1;
      rdata_d  = bus.bus_rdata;
      rlast_d  = cnt_last;
      if (cnt_last) state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rdata_q  <= rdata_d;
      timer_q  <= timer_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_c;
  assign bus.wdata_ready = wdata_ready_c;
  assign bus.bus_wr      = bus_wr_c;
  assign bus.bus_rd      = bus_rd_c;
  assign bus.bus_wdata   = bus_wdata_c;
  assign bus.bus_address = addr_q;
  assign bus.bus_length  = len_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.rdata_valid = rvalid_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_last  = rlast_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_burst_bus_master.sv
// Directed bench for burst_bus_master: per-cycle vector table plus reset and timeout sequences.
module tb_burst_bus_master;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  burst_bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bif ();

  burst_bus_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bif)
  );

  typedef struct packed {
    logic        cv;
    logic        cw;
    logic [3:0]  a;
    logic [3:0]  l;
    logic        wv;
    logic [31:0] wd;
    logic        brdy;
    logic        rdv;
    logic [31:0] rd;
  } in_t;

  typedef struct packed {
    logic        cr;
    logic        busy;
    logic        bw;
    logic        brd;
    logic        wrdy;
    logic        err;
    logic        rv;
    logic        rl;
    logic [3:0]  a;
    logic [3:0]  l;
    logic [31:0] wd;
    logic [31:0] rd;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic in_t I(int unsigned cv, int unsigned cw, int unsigned a, int unsigned l,
                            int unsigned wv, int unsigned wd, int unsigned brdy,
                            int unsigned rdv, int unsigned rd);
    in_t r;
    r.cv = 1'(cv); r.cw = 1'(cw); r.a = 4'(a); r.l = 4'(l);
    r.wv = 1'(wv); r.wd = wd; r.brdy = 1'(brdy); r.rdv = 1'(rdv); r.rd = rd;
    return r;
  endfunction

  function automatic out_t O(int unsigned cr, int unsigned busy, int unsigned bw, int unsigned brd,
                             int unsigned wrdy, int unsigned err, int unsigned rv, int unsigned rl,
                             int unsigned a, int unsigned l, int unsigned wd, int unsigned rd);
    out_t r;
    r.cr = 1'(cr); r.busy = 1'(busy); r.bw = 1'(bw); r.brd = 1'(brd);
    r.wrdy = 1'(wrdy); r.err = 1'(err); r.rv = 1'(rv); r.rl = 1'(rl);
    r.a = 4'(a); r.l = 4'(l); r.wd = wd; r.rd = rd;
    return r;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t i);
    bif.cmd_valid       = i.cv;
    bif.cmd_wr          = i.cw;
    bif.cmd_addr        = i.a;
    bif.cmd_len         = i.l;
    bif.wdata_valid     = i.wv;
    bif.wdata           = i.wd;
    bif.bus_ready       = i.brdy;
    bif.bus_rddatavalid = i.rdv;
    bif.bus_rdata       = i.rd;
  endtask

  function automatic out_t sample();
    out_t r;
    r.cr = bif.cmd_ready; r.busy = bif.busy; r.bw = bif.bus_wr; r.brd = bif.bus_rd;
    r.wrdy = bif.wdata_ready; r.err = bif.err; r.rv = bif.rdata_valid; r.rl = bif.rdata_last;
    r.a = bif.bus_address; r.l = bif.bus_length; r.wd = bif.bus_wdata; r.rd = bif.rdata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  localparam int unsigned WA  = 32'hAAAA_0001;
  localparam int unsigned WB  = 32'hAAAA_0002;
  localparam int unsigned WC  = 32'hAAAA_0003;
  localparam int unsigned WD1 = 32'h1234_5678;
  localparam int unsigned WD2 = 32'h9ABC_DEF0;

  in_t idle_in;

  initial begin
    idle_in = I(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle_in);

    // write addr=1 len=3, bus_ready=1; stray read beat during the burst
    add(I(1, 1, 1, 3, 0, 0,   1, 0, 0),     O(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0));
    add(I(0, 0, 0, 0, 1, WA,  1, 0, 0),     O(0, 1, 1, 0, 1, 0, 0, 0, 1, 3, WA, 0));
    add(I(0, 0, 0, 0, 1, WB,  1, 1, 'h77),  O(0, 1, 1, 0, 1, 0, 0, 0, 1, 3, WB, 0));
    add(I(0, 0, 0, 0, 1, WC,  1, 0, 0),     O(0, 1, 1, 0, 1, 0, 0, 0, 1, 3, WC, 0));
    add(idle_in,                            O(1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0));
    // write addr=2 len=2, bus_ready low two cycles on beat 1, then a gap
    add(I(1, 1, 2, 2, 0, 0,   0, 0, 0),     O(1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,   0));
    add(I(0, 0, 0, 0, 1, WD1, 0, 0, 0),     O(0, 1, 1, 0, 0, 0, 0, 0, 2, 2, WD1, 0));
    add(I(0, 0, 0, 0, 1, WD1, 0, 0, 0),     O(0, 1, 1, 0, 0, 0, 0, 0, 2, 2, WD1, 0));
    add(I(0, 0, 0, 0, 1, WD1, 1, 0, 0),     O(0, 1, 1, 0, 1, 0, 0, 0, 2, 2, WD1, 0));
    add(I(0, 0, 0, 0, 0, 0,   1, 0, 0),     O(0, 1, 0, 0, 1, 0, 0, 0, 2, 2, 0,   0));
    add(I(0, 0, 0, 0, 1, WD2, 1, 0, 0),     O(0, 1, 1, 0, 1, 0, 0, 0, 2, 2, WD2, 0));
    // len=0 command
    add(I(1, 1, 5, 0, 0, 0,   0, 0, 0),     O(1, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0));
    add(idle_in,                            O(1, 0, 0, 0, 0, 1, 0, 0, 5, 0, 0, 0));
    add(idle_in,                            O(1, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0));
    // read addr=1 len=1, bus_ready on 2nd cycle, data 2 cycles later; stray beat in IDLE
    add(I(1, 0, 1, 1, 0, 0,   0, 0, 0),     O(1, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0));
    add(idle_in,                            O(0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    add(I(0, 0, 0, 0, 0, 0,   1, 0, 0),     O(0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    add(idle_in,                            O(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add(I(0, 0, 0, 0, 0, 0,   0, 1, 'hA),   O(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add(idle_in,                            O(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 'hA));
    add(I(0, 0, 0, 0, 0, 0,   0, 1, 'h55),  O(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'hA));
    add(idle_in,                            O(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'hA));
    // read addr=3 len=2, first beat in the same cycle as bus_ready
    add(I(1, 0, 3, 2, 0, 0,   0, 0, 0),     O(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'hA));
    add(I(0, 0, 0, 0, 0, 0,   1, 1, 'h11),  O(0, 1, 0, 1, 0, 0, 0, 0, 3, 2, 0, 'hA));
    add(I(0, 0, 0, 0, 0, 0,   0, 1, 'h22),  O(0, 1, 0, 0, 0, 0, 1, 0, 3, 2, 0, 'h11));
    add(idle_in,                            O(1, 0, 0, 0, 0, 0, 1, 1, 3, 2, 0, 'h22));

    #2;
    chk("reset_busy", 128'(bif.busy), 128'(0));
    chk("reset_bus_wr", 128'(bif.bus_wr), 128'(0));
    chk("reset_err", 128'(bif.err), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].i);
      #1;
      chk($sformatf("vec%0d", k), 128'(sample()), 128'(tbl[k].o));
    end

    // reset asserted during beat 2 of a 4-beat write
    @(negedge clk); drive(I(1, 1, 9, 4, 0, 0, 0, 0, 0));
    @(negedge clk); drive(I(0, 0, 0, 0, 1, 'h1, 1, 0, 0));
    @(negedge clk); drive(I(0, 0, 0, 0, 1, 'h2, 1, 0, 0));
    #1;
    chk("rst_pre_bus_wr", 128'(bif.bus_wr), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_bus_wr", 128'(bif.bus_wr), 128'(0));
    chk("rst_busy", 128'(bif.busy), 128'(0));
    chk("rst_address", 128'(bif.bus_address), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle_in);
    #1;
    chk("rel_cmd_ready", 128'(bif.cmd_ready), 128'(1));
    chk("rel_length", 128'(bif.bus_length), 128'(0));

    // read len=4, only 2 beats arrive, timeout after TO idle cycles
    @(negedge clk); drive(I(1, 0, 2, 4, 0, 0, 0, 0, 0));
    @(negedge clk); drive(I(0, 0, 0, 0, 0, 0, 1, 0, 0));
    @(negedge clk); drive(I(0, 0, 0, 0, 0, 0, 0, 1, 'h101));
    @(negedge clk); drive(I(0, 0, 0, 0, 0, 0, 0, 1, 'h102));
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      drive(idle_in);
      #1;
      if (j == 1) chk("to_beat2_data", 128'({bif.rdata_valid, bif.rdata}), 128'({1'b1, 32'h102}));
      chk($sformatf("to_err_%0d", j), 128'(bif.err), 128'(j == 9));
      chk($sformatf("to_busy_%0d", j), 128'(bif.busy), 128'(j <= 8));
      chk($sformatf("to_last_%0d", j), 128'(bif.rdata_last), 128'(0));
    end
    @(negedge clk); drive(I(0, 0, 0, 0, 0, 0, 0, 1, 'h103));
    #1;
    chk("to_err_clear", 128'(bif.err), 128'(0));
    @(negedge clk); drive(idle_in);
    #1;
    chk("to_stray_ignored", 128'({bif.rdata_valid, bif.rdata_last, bif.cmd_ready}), 128'(3'b001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
